wb_scoreboard: RTL and testbench

Writeback and hazard-tracking stage that drives the write port of the core's 32x32 register file. It merges single-cycle ALU results and multi-cycle load results into one registered write (`rf_we`/`rf_waddr`/`rf_wdata`). It also keeps a pending-destination scoreboard so decode can stall on RAW/WAW hazards. It sits between execute/LSU and the register file; decode queries it every cycle.

---
 rtl/wb_scoreboard.sv | 134 +++++++++++++
 tb/tb_wb_scoreboard.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : wb_scoreboard
// Purpose  : Writeback merge of ALU/load results into the register-file write
//            port, plus a pending-destination scoreboard for decode hazards.
// Revision : 1.0
// ============================================================================
module wb_scoreboard #(
    parameter  int MAX_LOADS = 4,
    localparam int CW        = $clog2(MAX_LOADS + 1)
) (
    input  logic          clk,
    input  logic          rstn,

    input  logic          issue_valid,
    input  logic [4:0]    issue_rd,
    output logic          issue_ready,

    input  logic          alu_valid,
    input  logic [4:0]    alu_rd,
    input  logic [31:0]   alu_data,

    input  logic          lsu_valid,
    input  logic [4:0]    lsu_rd,
    input  logic [31:0]   lsu_data,
    output logic          lsu_ready,

    input  logic [4:0]    q_rs1,
    input  logic [4:0]    q_rs2,
    input  logic [4:0]    q_rd,
    output logic          stall,

    output logic          rf_we,
    output logic [4:0]    rf_waddr,
    output logic [31:0]   rf_wdata,
    output logic [31:0]   pending,
    output logic [CW-1:0] outstanding
);

    localparam logic [CW-1:0] c_MAX_LOADS = CW'(MAX_LOADS);
    localparam logic [CW-1:0] c_ONE       = CW'(1);

    logic          rf_we_q,       rf_we_d;
    logic [4:0]    rf_waddr_q,    rf_waddr_d;
    logic [31:0]   rf_wdata_q,    rf_wdata_d;
    logic [31:0]   pending_q,     pending_d;
    logic [CW-1:0] outstanding_q, outstanding_d;

    logic          w_issue_ready;
    logic          w_issue_set;
    logic          w_lsu_acc;
    logic          w_lsu_clr;
    logic          w_sel_valid;
    logic [4:0]    w_sel_rd;
    logic [31:0]   w_sel_data;
    logic          w_hit_rs1;
    logic          w_hit_rs2;

    // Scoreboard state is read pre-edge, so an issue to an rd completing this
    // cycle is refused and retried by decode.
    assign w_issue_ready = (outstanding_q < c_MAX_LOADS) && !pending_q[issue_rd];
    assign w_issue_set   = issue_valid && w_issue_ready && (issue_rd != 5'd0);

    assign w_lsu_acc   = lsu_valid && !alu_valid;
    assign w_lsu_clr   = w_lsu_acc && pending_q[lsu_rd];

    assign w_sel_valid = alu_valid || lsu_valid;
    assign w_sel_rd    = alu_valid ? alu_rd   : lsu_rd;
    assign w_sel_data  = alu_valid ? alu_data : lsu_data;

    always_comb begin
        rf_we_d    = w_sel_valid && (w_sel_rd != 5'd0);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (w_sel_valid) begin
            rf_waddr_d = w_sel_rd;
            rf_wdata_d = w_sel_data;
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (w_lsu_clr) begin
            pending_d[lsu_rd] = 1'b0;
        end
        if (w_issue_set) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        outstanding_d = outstanding_q;
        case ({w_issue_set, w_lsu_clr})
            2'b10:   outstanding_d = outstanding_q + c_ONE;
            2'b01:   outstanding_d = outstanding_q - c_ONE;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= 5'd0;
            rf_wdata_q    <= 32'd0;
            pending_q     <= 32'd0;
            outstanding_q <= '0;
        end else begin
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
        end
    end

    // The in-flight write term covers the cycle before the register file commits.
    assign w_hit_rs1 = (q_rs1 != 5'd0) &&
                       (pending_q[q_rs1] || (rf_we_q && (rf_waddr_q == q_rs1)));
    assign w_hit_rs2 = (q_rs2 != 5'd0) &&
                       (pending_q[q_rs2] || (rf_we_q && (rf_waddr_q == q_rs2)));

    assign stall       = w_hit_rs1 || w_hit_rs2 || pending_q[q_rd];
    assign issue_ready = w_issue_ready;
    assign lsu_ready   = !alu_valid;

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign pending     = pending_q;
    assign outstanding = outstanding_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_scoreboard
// Purpose  : Directed plus randomized bench for wb_scoreboard against a
//            queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_wb_scoreboard;

    localparam int MAX_LOADS = 4;
    localparam int CW        = $clog2(MAX_LOADS + 1);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          issue_valid = 1'b0;
    logic [4:0]    issue_rd = 5'd0;
    logic          issue_ready;
    logic          alu_valid = 1'b0;
    logic [4:0]    alu_rd = 5'd0;
    logic [31:0]   alu_data = 32'd0;
    logic          lsu_valid = 1'b0;
    logic [4:0]    lsu_rd = 5'd0;
    logic [31:0]   lsu_data = 32'd0;
    logic          lsu_ready;
    logic [4:0]    q_rs1 = 5'd0;
    logic [4:0]    q_rs2 = 5'd0;
    logic [4:0]    q_rd = 5'd0;
    logic          stall;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic [31:0]   pending;
    logic [CW-1:0] outstanding;

    wb_scoreboard #(.MAX_LOADS(MAX_LOADS)) dut (
        .clk(clk), .rstn(rstn),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd), .stall(stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pending(pending), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int warns    = 0;

    // Reference model: set of outstanding load destinations plus last write.
    int          m_q[$];
    logic        m_we    = 1'b0;
    logic [4:0]  m_waddr = 5'd0;
    logic [31:0] m_wdata = 32'd0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_has(input int r);
        foreach (m_q[i]) if (m_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_vec();
        logic [31:0] v = 32'd0;
        foreach (m_q[i]) v[m_q[i]] = 1'b1;
        return v;
    endfunction

    function automatic bit m_hit(input int r);
        return (r != 0) && (m_has(r) || (m_we && (m_waddr == r)));
    endfunction

    task automatic m_clear();
        m_q.delete();
        m_we    = 1'b0;
        m_waddr = 5'd0;
        m_wdata = 32'd0;
    endtask

    task automatic drive(input bit iv, input logic [4:0] ird,
                         input bit av, input logic [4:0] ard, input logic [31:0] adat,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        @(negedge clk);
        issue_valid = iv;  issue_rd = ird;
        alu_valid   = av;  alu_rd   = ard; alu_data = adat;
        lsu_valid   = lv;  lsu_rd   = lrd; lsu_data = ldat;
        q_rs1 = r1; q_rs2 = r2; q_rd = rd;
    endtask

    // Compare every output with the model, then advance the model one edge.
    task automatic step();
        bit exp_ir;
        #1;
        exp_ir = (m_q.size() < MAX_LOADS) && !m_has(int'(issue_rd));
        check_val("issue_ready", issue_ready, exp_ir);
        check_val("lsu_ready",   lsu_ready,   !alu_valid);
        check_val("stall",       stall,
                  m_hit(int'(q_rs1)) || m_hit(int'(q_rs2)) || m_has(int'(q_rd)));
        check_val("rf_we",       rf_we,       m_we);
        check_val("rf_waddr",    rf_waddr,    m_waddr);
        check_val("rf_wdata",    rf_wdata,    m_wdata);
        check_val("pending",     pending,     m_vec());
        check_val("outstanding", outstanding, m_q.size());
        @(posedge clk);
        if (alu_valid) begin
            m_we = (alu_rd != 0); m_waddr = alu_rd; m_wdata = alu_data;
        end else if (lsu_valid) begin
            m_we = (lsu_rd != 0); m_waddr = lsu_rd; m_wdata = lsu_data;
            if (m_has(int'(lsu_rd))) begin
                foreach (m_q[i]) if (m_q[i] == int'(lsu_rd)) begin m_q.delete(i); break; end
            end else begin
                warns++;
            end
        end else begin
            m_we = 1'b0;
        end
        if (issue_valid && exp_ir && issue_rd != 0) m_q.push_back(int'(issue_rd));
        #1;
    endtask

    task automatic do_reset();
        #2;
        rstn = 1'b0;
        #1;
        check_val("rst_we",    rf_we,       1'b0);
        check_val("rst_waddr", rf_waddr,    5'd0);
        check_val("rst_wdata", rf_wdata,    32'd0);
        check_val("rst_pend",  pending,     32'd0);
        check_val("rst_outst", outstanding, 0);
        m_clear();
        drive(0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        rstn = 1'b1;
        #1;
        check_val("rst_issue_ready", issue_ready, 1'b1);
        check_val("rst_stall",       stall,       1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hold;
        int r;
        m_clear();
        repeat (2) @(posedge clk);
        do_reset();

        // ALU write and in-flight hazard
        drive(0, 5'd0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        step();
        alu_valid = 1'b0; q_rs1 = 5'd5;
        #1;
        check_val("alu_we",    rf_we,    1'b1);
        check_val("alu_waddr", rf_waddr, 5'd5);
        check_val("alu_wdata", rf_wdata, 32'hDEADBEEF);
        check_val("alu_stall_n1", stall, 1'b1);
        drive(0, 5'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd0);
        step();
        check_val("alu_stall_n2", stall, 1'b0);
        drive(0, 5'd0, 1, 5'd0, 32'h12345678, 0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        step();
        check_val("alu_x0_we", rf_we, 1'b0);

        // Scoreboard fill
        for (int i = 1; i <= 4; i++) begin
            drive(1, 5'(i), 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
            step();
        end
        issue_valid = 1'b0; issue_rd = 5'd5; q_rs2 = 5'd3;
        #1;
        check_val("fill_outst", outstanding, 4);
        check_val("fill_pend",  pending,     32'h1E);
        check_val("fill_ready", issue_ready, 1'b0);
        check_val("fill_stall", stall,       1'b1);
        drive(0, 5'd5, 0, 5'd0, 32'd0, 1, 5'd3, 32'hA5A5_0003, 5'd0, 5'd0, 5'd0);
        step();
        lsu_valid = 1'b0;
        #1;
        check_val("cpl_outst", outstanding, 3);
        check_val("cpl_ready", issue_ready, 1'b1);

        // ALU/LSU conflict
        drive(1, 5'd7, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        step();
        drive(0, 5'd0, 1, 5'd10, 32'h1234, 1, 5'd7, 32'h55, 5'd0, 5'd0, 5'd0);
        #1;
        check_val("conf_lsu_ready", lsu_ready, 1'b0);
        step();
        check_val("conf_alu_waddr", rf_waddr,   5'd10);
        check_val("conf_alu_wdata", rf_wdata,   32'h1234);
        check_val("conf_pend7_set", pending[7], 1'b1);
        drive(0, 5'd0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h55, 5'd0, 5'd0, 5'd0);
        step();
        check_val("conf_lsu_we",    rf_we,      1'b1);
        check_val("conf_lsu_waddr", rf_waddr,   5'd7);
        check_val("conf_lsu_wdata", rf_wdata,   32'h55);
        check_val("conf_pend7_clr", pending[7], 1'b0);

        // Same-cycle issue and completion
        drive(1, 5'd6, 0, 5'd0, 32'd0, 1, 5'd2, 32'h22, 5'd0, 5'd0, 5'd0);
        #1;
        check_val("same_ready", issue_ready, 1'b1);
        step();
        check_val("same_outst", outstanding, 3);
        check_val("same_bit2",  pending[2],  1'b0);
        check_val("same_bit6",  pending[6],  1'b1);
        drive(1, 5'd2, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        step();
        drive(1, 5'd2, 0, 5'd0, 32'd0, 1, 5'd2, 32'h2222, 5'd0, 5'd0, 5'd0);
        #1;
        check_val("reissue_cpl_ready", issue_ready, 1'b0);
        step();

        // Issue to a pending rd
        drive(1, 5'd9, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        step();
        drive(1, 5'd9, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd9);
        #1;
        check_val("dup_ready", issue_ready, 1'b0);
        step();
        drive(1, 5'd9, 0, 5'd0, 32'd0, 1, 5'd9, 32'h99, 5'd0, 5'd0, 5'd0);
        step();
        drive(1, 5'd9, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        #1;
        check_val("dup_retry_ready", issue_ready, 1'b1);
        step();

        // Reset with loads outstanding
        do_reset();

        // Randomized traffic with a protocol-respecting LSU and ALU
        hold = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                do_reset();
                hold = 1'b0;
            end
            @(negedge clk);
            if (!hold) begin
                lsu_valid = ($urandom_range(99) < 40);
                if (m_q.size() > 0 && $urandom_range(9) != 0)
                    lsu_rd = 5'(m_q[$urandom_range(m_q.size() - 1)]);
                else
                    lsu_rd = 5'($urandom);
                lsu_data = $urandom;
            end
            alu_valid = ($urandom_range(99) < 30);
            do r = $urandom_range(31); while (m_has(r));
            alu_rd      = 5'(r);
            alu_data    = $urandom;
            issue_valid = ($urandom_range(99) < 45);
            issue_rd    = ($urandom_range(3) == 0) ? 5'($urandom_range(3)) : 5'($urandom);
            q_rs1 = 5'($urandom);
            q_rs2 = 5'($urandom);
            q_rd  = 5'($urandom);
            hold  = lsu_valid && alu_valid;
            step();
        end

        $display("protocol warnings (lsu beat to non-pending rd): %0d", warns);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
